obb_update_scheduler: RTL and testbench

Sequences one physics step for every OBB in the object state memory, once per frame. On each frame tick it walks slots 0..N_OBJ-1, reads each packed OBB, feeds it through the combinational OBB updater, and writes the next state back to the same slot. Between passes it arbitrates the state memory for one external requester, such as collision or render readout, so the updater and the external client never collide on the memory port.

---
 rtl/obb_update_scheduler.sv | 104 ++++++++++
 tb/tb_obb_update_scheduler.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obb_update_scheduler.sv
// rtl/obb_update_scheduler.sv - per-frame OBB physics pass sequencer with external memory arbitration
module obb_update_scheduler #(
  parameter int N_OBJ = 8,
  parameter int IDX_W = 3,
  parameter int OBB_W = 96
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             frame_tick,
  output logic [IDX_W-1:0] mem_addr,
  output logic             mem_rd,
  input  logic [OBB_W-1:0] mem_rdata,
  output logic             mem_wr,
  output logic [OBB_W-1:0] mem_wdata,
  output logic [OBB_W-1:0] upd_prev,
  input  logic [OBB_W-1:0] upd_next,
  input  logic             ext_req,
  output logic             ext_gnt,
  output logic             busy,
  output logic             done,
  output logic             overrun,
  output logic [15:0]      pass_count
);

  typedef enum logic [2:0] {IDLE, READ, LATCH, WRITE, DONE} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic             pend;
  logic             tick;
  logic             start;
  logic             last;

  assign tick      = frame_tick & enable;
  // A pending or fresh frame always beats a same-cycle ext_req, but never preempts a live grant.
  assign start     = (state == IDLE) && (pend || tick) && !ext_gnt;
  assign last      = (idx == IDX_W'(N_OBJ - 1));
  assign mem_addr  = idx;
  assign mem_wdata = upd_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = READ;
      READ:  begin
        mem_rd    = 1'b1;
        busy      = 1'b1;
        state_nxt = LATCH;
      end
      LATCH: begin
        busy      = 1'b1;
        state_nxt = WRITE;
      end
      WRITE: begin
        mem_wr    = 1'b1;
        busy      = 1'b1;
        state_nxt = last ? DONE : READ;
      end
      DONE:  begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx        <= '0;
      pend       <= 1'b0;
      upd_prev   <= '0;
      ext_gnt    <= 1'b0;
      overrun    <= 1'b0;
      pass_count <= '0;
    end else begin
      // Grant only changes in IDLE; it tracks ext_req one edge late and is forced low outside IDLE.
      ext_gnt <= (state == IDLE) && !start && ext_req;

      if (start) begin
        pend <= 1'b0;
      end else if (tick) begin
        if (pend) overrun <= 1'b1;
        else      pend    <= 1'b1;
      end

      if (start)                         idx <= '0;
      else if (state == WRITE && !last)  idx <= idx + 1'b1;

      if (state == LATCH) upd_prev   <= mem_rdata;
      if (state == DONE)  pass_count <= pass_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_obb_update_scheduler.sv
// tb/tb_obb_update_scheduler.sv - directed and randomized bench for obb_update_scheduler
module tb_obb_update_scheduler;

  localparam int N  = 8;
  localparam int IW = 3;
  localparam int W  = 96;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          frame_tick = 1'b0;
  logic          ext_req = 1'b0;
  logic [IW-1:0] mem_addr;
  logic          mem_rd, mem_wr, ext_gnt, busy, done, overrun;
  logic [W-1:0]  mem_rdata, mem_wdata, upd_prev, upd_next;
  logic [15:0]   pass_count;

  logic [W-1:0]  mem     [N];
  logic [W-1:0]  ld_img  [N];
  logic [W-1:0]  ref_mem [N];
  logic [W-1:0]  snap    [N];
  logic          ld = 1'b1;

  int            checks = 0;
  int            errors = 0;

  // Reference model: pass described by its cycle offset from the start edge.
  bit            m_act, m_pend, m_gnt, m_ovr;
  int            m_k;
  logic [15:0]   m_cnt;
  int            n_busy, n_done, n_gstrobe;

  obb_update_scheduler #(.N_OBJ(N), .IDX_W(IW), .OBB_W(W)) dut (
    .clk(clk), .rst(rst), .enable(enable), .frame_tick(frame_tick),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .mem_wr(mem_wr), .mem_wdata(mem_wdata), .upd_prev(upd_prev),
    .upd_next(upd_next), .ext_req(ext_req), .ext_gnt(ext_gnt),
    .busy(busy), .done(done), .overrun(overrun), .pass_count(pass_count)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] mk(input logic [15:0] px, input logic [15:0] py,
                                      input logic [15:0] vx, input logic [15:0] vy,
                                      input logic [7:0] ang, input logic [7:0] om,
                                      input logic [7:0] wd, input logic [7:0] ht);
    return {px, py, vx, vy, ang, om, wd, ht};
  endfunction

  // Updater: reflect velocity on a negative coordinate, then integrate.
  function automatic logic [W-1:0] f(input logic [W-1:0] s);
    logic signed [15:0] px, py, vx, vy;
    logic [7:0]         ang;
    px = s[95:80];
    py = s[79:64];
    vx = s[63:48];
    vy = s[47:32];
    if (px < 0) vx = -vx;
    if (py < 0) vy = -vy;
    px  = px + vx;
    py  = py + vy;
    ang = s[31:24] + s[23:16];
    return {px, py, vx, vy, ang, s[23:0]};
  endfunction

  assign upd_next = f(upd_prev);

  always @(posedge clk) begin
    if (ld) begin
      for (int i = 0; i < N; i++) mem[i] <= ld_img[i];
    end else if (mem_wr) begin
      mem[mem_addr] <= mem_wdata;
    end
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    n_busy    = 0;
    n_done    = 0;
    n_gstrobe = 0;
  endtask

  task automatic cycle(input bit ft, input bit en, input bit req);
    bit busy_e, done_e, rd_e, wr_e, tk;
    int slot;
    frame_tick = ft;
    enable     = en;
    ext_req    = req;
    #1;
    busy_e = m_act && (m_k < 3 * N);
    done_e = m_act && (m_k == 3 * N);
    rd_e   = busy_e && (m_k % 3 == 0);
    wr_e   = busy_e && (m_k % 3 == 2);
    slot   = m_k / 3;
    chk("busy", W'(busy), W'(busy_e));
    chk("done", W'(done), W'(done_e));
    chk("mem_rd", W'(mem_rd), W'(rd_e));
    chk("mem_wr", W'(mem_wr), W'(wr_e));
    chk("ext_gnt", W'(ext_gnt), W'(m_gnt));
    chk("overrun", W'(overrun), W'(m_ovr));
    chk("pass_count", W'(pass_count), W'(m_cnt));
    if (rd_e || wr_e) chk("mem_addr", W'(mem_addr), W'(slot));
    if (wr_e) begin
      chk("upd_prev", upd_prev, ref_mem[slot]);
      chk("mem_wdata", mem_wdata, f(ref_mem[slot]));
      ref_mem[slot] = f(ref_mem[slot]);
    end
    n_busy    = n_busy + (busy ? 1 : 0);
    n_done    = n_done + (done ? 1 : 0);
    n_gstrobe = n_gstrobe + ((ext_gnt && (mem_rd || mem_wr)) ? 1 : 0);

    tk = ft && en;
    if (m_act) begin
      if (tk) begin
        if (m_pend) m_ovr = 1'b1;
        else        m_pend = 1'b1;
      end
      if (done_e) begin
        m_act = 1'b0;
        m_cnt = m_cnt + 16'd1;
      end else begin
        m_k++;
      end
    end else if ((m_pend || tk) && !m_gnt) begin
      m_act  = 1'b1;
      m_k    = 0;
      m_pend = 1'b0;
    end else begin
      if (tk) begin
        if (m_pend) m_ovr = 1'b1;
        else        m_pend = 1'b1;
      end
      m_gnt = req;
    end
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_done", W'(done), W'(0));
    chk("rst_mem_rd", W'(mem_rd), W'(0));
    chk("rst_mem_wr", W'(mem_wr), W'(0));
    chk("rst_ext_gnt", W'(ext_gnt), W'(0));
    chk("rst_overrun", W'(overrun), W'(0));
    chk("rst_pass_count", W'(pass_count), W'(0));
    chk("rst_mem_addr", W'(mem_addr), W'(0));
    chk("rst_upd_prev", upd_prev, W'(0));
    m_act  = 1'b0;
    m_pend = 1'b0;
    m_gnt  = 1'b0;
    m_ovr  = 1'b0;
    m_k    = 0;
    m_cnt  = 16'd0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] c0;
    bit          req;
    for (int i = 0; i < N; i++) begin
      ld_img[i]  = mk(16'(i), 16'(i), 16'd1, 16'd1, 8'd0, 8'd0, 8'($urandom), 8'($urandom));
      ref_mem[i] = ld_img[i];
    end
    @(negedge clk);
    pulse_reset();
    ld = 1'b0;
    clr();

    // Basic pass
    repeat (3) cycle(0, 1, 0);
    clr();
    cycle(1, 1, 0);
    repeat (30) cycle(0, 1, 0);
    chk("basic_busy_cycles", W'(n_busy), W'(24));
    chk("basic_done_cycles", W'(n_done), W'(1));
    chk("basic_pass_count", W'(pass_count), W'(1));
    for (int i = 0; i < N; i++) begin
      chk("basic_pos_x", W'(mem[i][95:80]), W'(i + 1));
      chk("basic_pos_y", W'(mem[i][79:64]), W'(i + 1));
    end

    // Bounce on slot 0
    for (int i = 0; i < N; i++) ld_img[i] = mem[i];
    ld_img[0]  = mk(16'hFFFF, 16'd5, 16'd2, 16'd0, 8'd10, 8'd3, 8'd8, 8'd8);
    ref_mem[0] = ld_img[0];
    ld = 1'b1;
    cycle(0, 1, 0);
    ld = 1'b0;
    cycle(1, 1, 0);
    repeat (30) cycle(0, 1, 0);
    chk("bounce_vel_x", W'(mem[0][63:48]), W'(16'hFFFE));
    chk("bounce_pos_x", W'(mem[0][95:80]), W'(16'hFFFD));
    cycle(1, 1, 0);
    repeat (30) cycle(0, 1, 0);
    chk("bounce2_pos_x", W'(mem[0][95:80]), W'(16'hFFFF));

    // Back-to-back: one pending tick absorbed
    clr();
    c0 = pass_count;
    cycle(1, 1, 0);
    repeat (4) cycle(0, 1, 0);
    cycle(1, 1, 0);
    repeat (60) cycle(0, 1, 0);
    chk("b2b_overrun", W'(overrun), W'(0));
    chk("b2b_busy_cycles", W'(n_busy), W'(48));
    chk("b2b_pass_count", W'(pass_count), W'(c0 + 16'd2));

    // Arbitration: grant held, tick waits
    clr();
    cycle(0, 1, 1);
    chk("arb_gnt_rise", W'(ext_gnt), W'(1));
    cycle(1, 1, 1);
    repeat (3) cycle(0, 1, 1);
    chk("arb_pass_held", W'(busy), W'(0));
    cycle(0, 1, 0);
    chk("arb_gnt_fall", W'(ext_gnt), W'(0));
    cycle(0, 1, 0);
    chk("arb_pass_start", W'(busy), W'(1));
    repeat (30) cycle(0, 1, 0);
    chk("arb_busy_cycles", W'(n_busy), W'(24));
    chk("arb_no_strobes", W'(n_gstrobe), W'(0));

    // Tick and ext_req together: pass wins, grant follows after DONE
    clr();
    cycle(1, 1, 1);
    repeat (30) cycle(0, 1, 1);
    chk("tie_busy_cycles", W'(n_busy), W'(24));
    chk("tie_gnt_after", W'(ext_gnt), W'(1));
    repeat (3) cycle(0, 1, 0);

    // enable low: ticks ignored, and a pass survives enable falling
    clr();
    repeat (5) cycle(1, 0, 0);
    repeat (10) cycle(0, 1, 0);
    chk("en0_no_busy", W'(n_busy), W'(0));
    clr();
    cycle(1, 1, 0);
    cycle(0, 1, 0);
    repeat (30) cycle(0, 0, 0);
    chk("en_drop_busy", W'(n_busy), W'(24));
    chk("en_drop_done", W'(n_done), W'(1));

    // Three ticks in one pass: overrun
    clr();
    c0 = pass_count;
    cycle(1, 1, 0);
    repeat (4) cycle(0, 1, 0);
    cycle(1, 1, 0);
    repeat (4) cycle(0, 1, 0);
    cycle(1, 1, 0);
    repeat (60) cycle(0, 1, 0);
    chk("ovr_overrun", W'(overrun), W'(1));
    chk("ovr_pass_count", W'(pass_count), W'(c0 + 16'd2));
    chk("ovr_busy_cycles", W'(n_busy), W'(48));

    // Reset during slot 3 READ
    for (int i = 0; i < N; i++) snap[i] = ref_mem[i];
    clr();
    cycle(1, 1, 0);
    repeat (9) cycle(0, 1, 0);
    chk("rst_at_read", W'(mem_rd), W'(1));
    chk("rst_at_slot3", W'(mem_addr), W'(3));
    pulse_reset();
    chk("rst_no_done", W'(n_done), W'(0));
    for (int i = 0; i < N; i++)
      chk("rst_mem_slot", mem[i], (i < 3) ? f(snap[i]) : snap[i]);
    cycle(0, 1, 0);
    clr();
    cycle(1, 1, 0);
    repeat (30) cycle(0, 1, 0);
    chk("post_rst_count", W'(pass_count), W'(1));
    chk("post_rst_busy", W'(n_busy), W'(24));
    for (int i = 0; i < N; i++) chk("post_rst_mem", mem[i], ref_mem[i]);

    // Randomized traffic
    req = 1'b0;
    repeat (800) begin
      if ($urandom_range(0, 9) == 0) req = ~req;
      cycle(($urandom_range(0, 19) == 0), ($urandom_range(0, 7) != 0), req);
    end
    repeat (40) cycle(0, 1, 0);
    for (int i = 0; i < N; i++) chk("rand_mem", mem[i], ref_mem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
